// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: one byte per CS-low frame, MSB first,
// with MISO captured on every SCK rising edge and a minimum CS-high gap
// enforced between consecutive frames. Every output comes from a flop.
module spi_master_tx #(
   parameter int HALF_PERIOD = 5,   // i_clk cycles per SCK half-period (>=1)
   parameter int GAP_CYCLES  = 10   // minimum CS-high cycles between frames (>=1)
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   input  logic       i_spi_miso,
   output logic       o_spi_clk,
   output logic       o_spi_mosi,
   output logic       o_spi_cs,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_busy
);

   localparam int HC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int GC_W = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);
   localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [HC_W-1:0] hc_q, hc_d;
   logic [2:0]      bc_q, bc_d;
   logic [GC_W-1:0] gc_q, gc_d;
   logic [7:0]      tx_sr_q, tx_sr_d;
   logic [7:0]      rx_sr_q, rx_sr_d;
   logic            spi_clk_q, spi_clk_d;
   logic            spi_mosi_q, spi_mosi_d;
   logic            spi_cs_q, spi_cs_d;
   logic            tx_ready_q, tx_ready_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            busy_q, busy_d;

   logic accept;
   logic hc_last;
   logic gc_last;

   // Handshake only completes in IDLE while the registered ready is high.
   assign accept  = (state_q == IDLE) && i_tx_valid && tx_ready_q;
   assign hc_last = (hc_q == HC_LAST);
   assign gc_last = (gc_q == GC_LAST);

   // State register with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of block evaluation order.
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: LOW/HIGH alternate per half-period, eight bits per frame.
   always_comb begin
      // NOTE: defaulting every comb output first keeps paths that do not
      // assign it from inferring a latch.
      state_d = state_q;
      case (state_q)
         IDLE: if (accept)  state_d = LOW;
         LOW:  if (hc_last) state_d = HIGH;
         HIGH: if (hc_last) state_d = (bc_q == 3'd7) ? GAP : LOW;
         GAP:  if (gc_last) state_d = IDLE;
         default:           state_d = IDLE;
      endcase
   end

   // Output/datapath decode: next values for the registered pins and counters.
   always_comb begin
      hc_d       = hc_q;
      bc_d       = bc_q;
      gc_d       = gc_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      spi_clk_d  = spi_clk_q;
      spi_mosi_d = spi_mosi_q;
      spi_cs_d   = spi_cs_q;
      tx_ready_d = 1'b0;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      busy_d     = (state_d != IDLE);

      case (state_q)
         IDLE: begin
            if (accept) begin
               // CS falls with the first data bit already on MOSI.
               tx_sr_d    = i_tx_data;
               spi_cs_d   = 1'b0;
               spi_clk_d  = 1'b0;
               spi_mosi_d = i_tx_data[7];
               bc_d       = 3'd0;
               hc_d       = '0;
            end else begin
               tx_ready_d = 1'b1;
            end
         end
         LOW: begin
            if (hc_last) begin
               spi_clk_d = 1'b1;
               rx_sr_d   = {rx_sr_q[6:0], i_spi_miso};
               hc_d      = '0;
            end else begin
               hc_d = hc_q + 1'b1;
            end
         end
         HIGH: begin
            if (hc_last) begin
               hc_d      = '0;
               spi_clk_d = 1'b0;
               if (bc_q != 3'd7) begin
                  // MOSI only moves on the SCK falling transition.
                  spi_mosi_d = tx_sr_q[6];
                  tx_sr_d    = {tx_sr_q[6:0], 1'b0};
                  bc_d       = bc_q + 3'd1;
               end else begin
                  spi_cs_d   = 1'b1;
                  spi_mosi_d = 1'b0;
                  rx_data_d  = rx_sr_q;
                  rx_valid_d = 1'b1;
                  gc_d       = '0;
               end
            end else begin
               hc_d = hc_q + 1'b1;
            end
         end
         GAP: begin
            if (gc_last) begin
               gc_d       = '0;
               tx_ready_d = 1'b1;
            end else begin
               gc_d = gc_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers; reset aborts any frame in progress.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         hc_q       <= '0;
         bc_q       <= 3'd0;
         gc_q       <= '0;
         // NOTE: the shift registers are reset too, so nothing after reset
         // depends on leftover contents of a discarded partial byte.
         tx_sr_q    <= 8'h00;
         rx_sr_q    <= 8'h00;
         spi_clk_q  <= 1'b0;
         spi_mosi_q <= 1'b0;
         spi_cs_q   <= 1'b1;
         tx_ready_q <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         hc_q       <= hc_d;
         bc_q       <= bc_d;
         gc_q       <= gc_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         spi_clk_q  <= spi_clk_d;
         spi_mosi_q <= spi_mosi_d;
         spi_cs_q   <= spi_cs_d;
         tx_ready_q <= tx_ready_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign o_tx_ready = tx_ready_q;
   assign o_spi_clk  = spi_clk_q;
   assign o_spi_mosi = spi_mosi_q;
   assign o_spi_cs   = spi_cs_q;
   assign o_rx_data  = rx_data_q;
   assign o_rx_valid = rx_valid_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: stimulus pushes expected frames to a
// scoreboard queue, a monitor pops and compares them at each CS rise.
module tb_spi_master_tx;

   localparam int HP  = 5;
   localparam int GAP = 10;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
   } frame_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       spi_miso;
   logic       spi_clk;
   logic       spi_mosi;
   logic       spi_cs;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   // miso_mode: 0 = tied low, 1 = tied high, 2 = loopback from MOSI
   logic [1:0] miso_mode;
   frame_t     exp_q[$];
   logic       check_gap;

   // monitor state
   logic       prev_cs, prev_sck, prev_ready, prev_rx_valid;
   int         cs_low_cnt, cs_high_cnt, rise_cnt;
   logic [7:0] mosi_cap;
   logic       seen_frame;

   assign spi_miso = (miso_mode == 2'd2) ? spi_mosi : miso_mode[0];

   spi_master_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_tx_data  (tx_data),
      .i_tx_valid (tx_valid),
      .o_tx_ready (tx_ready),
      .i_spi_miso (spi_miso),
      .o_spi_clk  (spi_clk),
      .o_spi_mosi (spi_mosi),
      .o_spi_cs   (spi_cs),
      .o_rx_data  (rx_data),
      .o_rx_valid (rx_valid),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rx_expect(input logic [7:0] d);
      case (miso_mode)
         2'd0:    return 8'h00;
         2'd1:    return 8'hFF;
         default: return d;
      endcase
   endfunction

   // Present a byte and return at the negedge after the accepting edge.
   task automatic send(input logic [7:0] d, input bit hold);
      frame_t f;
      bit     done;
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      f.tx = d;
      f.rx = rx_expect(d);
      exp_q.push_back(f);
      done = 0;
      for (int n = 0; n < 2000 && !done; n++) begin
         if (tx_ready) begin
            @(posedge clk);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      check("accept_timeout", {31'd0, done}, 32'd1);
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge clk);
      check("frames_pending", exp_q.size(), 32'd0);
   endtask

   // Monitor: sample 1 time unit after each rising edge.
   always @(posedge clk) begin
      frame_t f;
      #1;
      if (!rst_n) begin
         cs_low_cnt  = 0;
         cs_high_cnt = 0;
         rise_cnt    = 0;
         mosi_cap    = 8'h00;
         seen_frame  = 1'b0;
      end else begin
         if (rx_valid)
            check("rx_valid_pulse", {29'd0, prev_cs, spi_cs, prev_rx_valid}, 32'b010);
         if (prev_ready && tx_valid)
            check("accept_edge", {30'd0, tx_ready, spi_cs}, 32'b00);
         if (!spi_cs) begin
            if (prev_cs && check_gap && seen_frame)
               check("cs_gap", cs_high_cnt, GAP + 1);
            cs_low_cnt++;
            if (spi_clk && !prev_sck) begin
               mosi_cap = {mosi_cap[6:0], spi_mosi};
               rise_cnt++;
            end
         end else begin
            if (!prev_cs) begin
               check("cs_low_len", cs_low_cnt, 16 * HP);
               check("sck_rises", rise_cnt, 8);
               vectors++;
               assert (exp_q.size() != 0)
               else begin
                  miscompares++;
                  $error("FAIL sb_underflow: observed frame with tx %0h, expected none", mosi_cap);
               end
               if (exp_q.size() != 0) begin
                  f = exp_q.pop_front();
                  check("mosi_bits", {24'd0, mosi_cap}, {24'd0, f.tx});
                  check("rx_data", {24'd0, rx_data}, {24'd0, f.rx});
               end
               seen_frame  = 1'b1;
               cs_low_cnt  = 0;
               cs_high_cnt = 0;
               rise_cnt    = 0;
               mosi_cap    = 8'h00;
            end
            cs_high_cnt++;
         end
      end
      prev_cs       = spi_cs;
      prev_sck      = spi_clk;
      prev_ready    = tx_ready;
      prev_rx_valid = rx_valid;
   end

   initial begin
      bit hit;
      rst_n     = 1'b0;
      tx_data   = 8'h00;
      tx_valid  = 1'b0;
      miso_mode = 2'd0;
      check_gap = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs",       {31'd0, spi_cs},   32'd1);
      check("rst_sck",      {31'd0, spi_clk},  32'd0);
      check("rst_mosi",     {31'd0, spi_mosi}, 32'd0);
      check("rst_ready",    {31'd0, tx_ready}, 32'd0);
      check("rst_rx_data",  {24'd0, rx_data},  32'h00);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", {31'd0, tx_ready}, 32'd1);

      // Single byte, MISO low
      send(8'h08, 0);
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      wait_done();

      // Loopback
      repeat (20) @(negedge clk);
      miso_mode = 2'd2;
      send(8'hC5, 0);
      wait_done();

      // MISO tied high, all-zero byte
      repeat (20) @(negedge clk);
      miso_mode = 2'd1;
      send(8'h00, 0);
      wait_done();

      // Back-to-back with valid held
      repeat (20) @(negedge clk);
      miso_mode = 2'd0;
      send(8'h08, 1);
      check_gap = 1'b1;
      send(8'h7F, 1);
      send(8'hFF, 0);
      wait_done();
      check_gap = 1'b0;

      // Valid pulse mid-frame is ignored
      repeat (20) @(negedge clk);
      miso_mode = 2'd2;
      send(8'hA3, 0);
      repeat (20) @(negedge clk);
      tx_data  = 8'h09;
      tx_valid = 1'b1;
      check("ready_mid_frame", {31'd0, tx_ready}, 32'd0);
      repeat (3) @(negedge clk);
      tx_valid = 1'b0;
      wait_done();
      repeat (40) @(negedge clk);
      check("idle_after_ignore_cs",   {31'd0, spi_cs}, 32'd1);
      check("idle_after_ignore_busy", {31'd0, busy},   32'd0);
      send(8'h09, 0);
      wait_done();

      // Reset after the 3rd SCK rise
      repeat (20) @(negedge clk);
      miso_mode = 2'd0;
      send(8'h7F, 0);
      hit = 0;
      for (int n = 0; n < 500 && !hit; n++) begin
         @(negedge clk);
         if (rise_cnt >= 3) hit = 1;
      end
      check("third_rise_seen", {31'd0, hit}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_cs",       {31'd0, spi_cs},   32'd1);
      check("abort_sck",      {31'd0, spi_clk},  32'd0);
      check("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("abort_busy",     {31'd0, busy},     32'd0);
      check("abort_rx_data",  {24'd0, rx_data},  32'h00);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h05, 0);
      wait_done();

      repeat (20) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI mode-0 master that serialises bytes, MSB first, onto SCK/MOSI/CS.
- Drives the byte-per-frame protocol that the SPI_PWM slave receives: one byte per CS-low frame, with a minimum CS-high gap between frames.
- Samples MISO on each SCK rising edge and returns the received byte.
- Sits between the core's I/O register logic and the external SPI pins.

Parameters:
HALF_PERIOD, 5, i_clk cycles per SCK half-period (>=1)
GAP_CYCLES, 10, minimum i_clk cycles CS stays high between frames (>=1)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_tx_data  input  8  byte to transmit
i_tx_valid  input  1  i_tx_data valid
o_tx_ready  output  1  block accepts a byte this cycle
i_spi_miso  input  1  serial data from slave
o_spi_clk  output  1  SCK, idles low
o_spi_mosi  output  1  serial data to slave
o_spi_cs  output  1  chip select, active-low
o_rx_data  output  8  byte shifted in from MISO during the last frame
o_rx_valid  output  1  one-cycle pulse when o_rx_data updates
o_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (i_rst_n low at an edge), values:
  - o_spi_cs=1, o_spi_clk=0, o_spi_mosi=0.
  - o_tx_ready=0, o_rx_data=8'h00, o_rx_valid=0, o_busy=0.
  - State IDLE; all counters 0.
- All outputs are registered.
- o_tx_ready=1 in IDLE from the first edge with i_rst_n high. It is 0 in all other states.
- Handshake: the byte is accepted on an edge where i_tx_valid && o_tx_ready.
  - i_tx_valid while not ready is ignored. The source holds data until it is accepted.
  - No internal buffering beyond a single shift register.
- States: IDLE, LOW, HIGH, GAP. Half-period counter hc counts 0..HALF_PERIOD-1. Bit counter bc is 3 bits.
- IDLE -> LOW on accept. On the same edge:
  - Latch the data into the shift register.
  - Set o_spi_cs=0, o_spi_clk=0, o_spi_mosi=i_tx_data[7]; bc=0, hc=0.
  - o_tx_ready falls on that edge.
- LOW lasts HALF_PERIOD cycles. At hc==HALF_PERIOD-1:
  - o_spi_clk=1.
  - i_spi_miso is shifted into the rx shift register, LSB in, MSB first.
  - Go to HIGH, hc=0.
- HIGH lasts HALF_PERIOD cycles. At hc==HALF_PERIOD-1:
  - If bc!=7: o_spi_clk=0, o_spi_mosi = next bit (MSB first), bc++, go to LOW.
  - If bc==7: o_spi_clk=0, o_spi_cs=1, o_spi_mosi=0, o_rx_data = rx shift register, o_rx_valid=1 for one cycle, go to GAP.
- MOSI changes only on SCK falling transitions, or at CS fall. It is stable for the full half-period before each SCK rise.
- Frame timing: CS low for exactly 16*HALF_PERIOD cycles, with 8 SCK rising edges per frame.
- GAP lasts GAP_CYCLES cycles with CS high. Then go to IDLE, and o_tx_ready=1 on that edge.
  - With i_tx_valid held continuously, CS is high for exactly GAP_CYCLES+1 cycles between frames (GAP plus the IDLE accept cycle).
- Reset mid-operation, from any state: on the next edge with i_rst_n low, return to reset values.
  - CS rises and SCK goes low immediately.
  - No o_rx_valid. The partial byte is discarded.
- Counter widths: ceil(log2) of the respective parameter, minimum 1 bit. No wrap occurs beyond the terminal values above.

Test Plan:
- Reset, then i_tx_data=8'h08 with valid and MISO=0 -> MOSI at the 8 SCK rises = 0,0,0,0,1,0,0,0; CS low 80 cycles; o_rx_valid pulse with o_rx_data=8'h00.
- Loopback MISO=MOSI, send 8'hC5 -> o_rx_data=8'hC5 and o_rx_valid high exactly 1 cycle, coincident with CS rise.
- MISO tied 1, send 8'h00 -> MOSI low throughout, o_rx_data=8'hFF.
- Back-to-back 8'h08, 8'h7F, 8'hFF with valid held -> three 80-cycle CS-low frames; CS high exactly 11 cycles between frames; o_tx_ready high only for one cycle per gap end.
- Toggle i_tx_valid with 8'h09 mid-frame -> ignored, current frame unaffected; 8'h09 is sent only after the gap.
- Pull i_rst_n low after the 3rd SCK rise of 8'h7F -> next edge CS=1, SCK=0, no o_rx_valid; after release, 8'h05 is transmitted intact with correct bits.
